multi_pattern_blinker: RTL and testbench
========================================

MULTI_PATTERN_BLINKER -- requirements
Module: multi_pattern_blinker

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent pattern channels (1..16).
REQ-002 SHALL have parameter PAT_W, default 32, pattern register width in bits (2..64).
REQ-003 SHALL have parameter PRESC_W, default 32, prescaler width in bits.
REQ-004 SHALL use one clock and asynchronous active-high reset: i_clk  in  1  system clock (16 MHz nominal); i_rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have i_cfg_valid  in  1  configuration request.
REQ-006 SHALL have o_cfg_ready  out  1  configuration can be accepted.
REQ-007 SHALL have i_cfg_ch  in  $clog2(CHANNELS) (min 1)  target channel.
REQ-008 SHALL have i_cfg_pattern  in  PAT_W  bit sequence, bit 0 shown first.
REQ-009 SHALL have i_cfg_len  in  $clog2(PAT_W)+1  active pattern length in bits.
REQ-010 SHALL have i_cfg_prescale  in  PRESC_W  clock cycles per pattern bit.
REQ-011 SHALL have i_cfg_oneshot  in  1  1 = play once, 0 = repeat.
REQ-012 SHALL have i_en  in  CHANNELS  per-channel run enable, level-sensitive.
REQ-013 SHALL have o_out  out  CHANNELS  registered per-channel pattern output.
REQ-014 SHALL have o_done  out  CHANNELS  one-cycle pulse at one-shot completion.

Function
REQ-015 SHALL give each channel states IDLE and RUN plus an ARMED flag; IDLE -> RUN when i_en[c]=1, ARMED=1 and active len != 0.
REQ-016 SHALL, on IDLE -> RUN, load bit index 0 and prescale count 0, with o_out[c]=pattern[0] on the next cycle.
REQ-017 SHALL hold each bit for max(prescale,1) cycles; prescale 0 behaves as 1.
REQ-018 SHALL, on the final prescale cycle of bit len-1, wrap to index 0 in repeat mode with no gap cycle.
REQ-019 SHALL, at that same point in one-shot mode, go to IDLE with o_out[c]=0, pulse o_done[c] for one cycle, and clear ARMED.
REQ-020 SHALL set ARMED only when i_en[c]=0 is sampled, so a one-shot replays only after i_en[c] falls and rises again.
REQ-021 SHALL, when i_en[c] falls in RUN, go to IDLE with o_out[c]=0 on the next cycle and no o_done pulse.
REQ-022 SHALL accept a configuration on the cycle where i_cfg_valid=1 and o_cfg_ready=1.
REQ-023 SHALL apply an accepted configuration the next cycle if the target channel is IDLE; otherwise it SHALL hold it in a per-channel shadow and apply it at the wrap or completion point of the current pattern, so the pattern never changes mid-sequence.
REQ-024 SHALL drive o_cfg_ready=0 while the channel selected by i_cfg_ch has a pending shadow, and 1 otherwise.
REQ-025 SHALL, when i_en[c] falls while a shadow is pending, apply the shadow on entry to IDLE.
REQ-026 SHALL treat len 0 as a disabled channel (stays IDLE) and clamp len > PAT_W to PAT_W.
REQ-027 SHALL ignore i_cfg_ch values >= CHANNELS, completing the handshake with no effect.

Reset
REQ-028 SHALL, on i_rst=1, immediately clear o_out, o_done, every state to IDLE, ARMED to 1, all shadows to empty, and all patterns, lengths and prescales to 0.
REQ-029 SHALL drive o_cfg_ready=1 from the first cycle after i_rst is released.
REQ-030 SHALL, if reset occurs mid-pattern or with a shadow pending, discard all state and let no o_done pulse occur.

Configuration
REQ-031 SHALL, when BLINKER_PWM_DIM_EN is defined, add input i_dim [3:0] and a free-running 4-bit counter, and drive o_out[c] as pattern bit AND (counter < i_dim), so i_dim=0 gives off and 15 gives 15/16 duty.
REQ-032 SHALL, when BLINKER_PWM_DIM_EN is undefined, have no i_dim port and no counter, with o_out[c] equal to the pattern bit.

Structure
REQ-033 SHALL place the channel state enum (IDLE, RUN) and the LEN_W helper constant/function in package blinker_pkg.
REQ-034 SHALL implement per-channel logic (prescaler, index, shadow, FSM) in sub-module blink_channel, instantiated CHANNELS times by generate; the top holds only cfg decode, ready mux and the optional dim counter.

Verification
REQ-035 SHALL verify: ch0 pattern=32'b1011, len=4, prescale=3, repeat, i_en[0]=1 -> o_out[0] shows 1,1,1,1,1,1,0,0,0,1,1,1 (bits 1,1,0,1 at 3 cycles each) and repeats with no gap.
REQ-036 SHALL verify: ch1 one-shot, pattern=2'b01, len=2, prescale=2 -> o_out[1] = 1,1,0,0, then 0 with one o_done[1] pulse; holding i_en high gives no replay, and a low-high toggle replays.
REQ-037 SHALL verify: ch2 running len=8 with a new cfg issued mid-pattern -> o_cfg_ready=0 for ch2 until the wrap, the new pattern starts exactly at index 0, and ready returns to 1.
REQ-038 SHALL verify: i_rst asserted mid-bit on all channels -> all outputs 0 in the same cycle, no o_done, and o_cfg_ready=1 after release.
REQ-039 SHALL verify: prescale=0 with len=1 -> the output is pattern[0] constantly; len=0 -> the channel stays IDLE and the output stays 0.
REQ-040 SHALL verify, with BLINKER_PWM_DIM_EN defined: i_dim=4 on an all-ones pattern -> the output is high 4 of every 16 cycles.

Source files
------------

// File: rtl/blinker_pkg.sv
// rtl/blinker_pkg.sv - channel state type and pattern-length width helper shared by the blinker files
package blinker_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  // Width needed to hold a pattern length of 0..pat_w inclusive.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w) + 1;
  endfunction

endpackage

// File: rtl/blink_channel.sv
// rtl/blink_channel.sv - one pattern channel: prescaler, bit index, config shadow and IDLE/RUN FSM
module blink_channel
  import blinker_pkg::*;
#(
  parameter int PAT_W   = 32,
  parameter int PRESC_W = 32,
  parameter int LEN_W   = len_w(PAT_W)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               cfg_we_i,
  input  logic [PAT_W-1:0]   cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic [PRESC_W-1:0] cfg_prescale_i,
  input  logic               cfg_oneshot_i,
  output logic               out_o,
  output logic               done_o,
  output logic               pending_o
);

  ch_state_e          state_q;
  logic               armed_q;
  logic               oneshot_q;
  logic               out_q;
  logic               done_q;
  logic [PAT_W-1:0]   pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   idx_q;
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] cnt_q;

  logic               sh_v_q;
  logic               sh_oneshot_q;
  logic [PAT_W-1:0]   sh_pat_q;
  logic [LEN_W-1:0]   sh_len_q;
  logic [PRESC_W-1:0] sh_presc_q;

  logic [LEN_W-1:0]   cfg_len_cl;
  logic               nxt_v_d;
  logic               nxt_oneshot_d;
  logic [PAT_W-1:0]   nxt_pat_d;
  logic [LEN_W-1:0]   nxt_len_d;
  logic [PRESC_W-1:0] nxt_presc_d;
  logic               bit_last;
  logic               pat_last;
  logic [LEN_W-1:0]   idx_inc;
  logic [PAT_W-1:0]   pat_shift;

  assign cfg_len_cl = (cfg_len_i > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len_i;

  // A config accepted on the very cycle a pass ends is taken directly rather than waiting a further pass.
  assign nxt_v_d       = cfg_we_i | sh_v_q;
  assign nxt_pat_d     = cfg_we_i ? cfg_pattern_i  : sh_pat_q;
  assign nxt_len_d     = cfg_we_i ? cfg_len_cl     : sh_len_q;
  assign nxt_presc_d   = cfg_we_i ? cfg_prescale_i : sh_presc_q;
  assign nxt_oneshot_d = cfg_we_i ? cfg_oneshot_i  : sh_oneshot_q;

  assign bit_last  = (presc_q <= PRESC_W'(1)) || (cnt_q == presc_q - PRESC_W'(1));
  assign pat_last  = (idx_q == len_q - LEN_W'(1));
  assign idx_inc   = idx_q + LEN_W'(1);
  assign pat_shift = pat_q >> idx_inc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      armed_q      <= 1'b1;
      oneshot_q    <= 1'b0;
      out_q        <= 1'b0;
      done_q       <= 1'b0;
      pat_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      presc_q      <= '0;
      cnt_q        <= '0;
      sh_v_q       <= 1'b0;
      sh_oneshot_q <= 1'b0;
      sh_pat_q     <= '0;
      sh_len_q     <= '0;
      sh_presc_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (!en_i) begin
        armed_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          out_q <= 1'b0;
          if (cfg_we_i) begin
            pat_q     <= cfg_pattern_i;
            len_q     <= cfg_len_cl;
            presc_q   <= cfg_prescale_i;
            oneshot_q <= cfg_oneshot_i;
          end else if (en_i && armed_q && (len_q != '0)) begin
            state_q <= RUN;
            idx_q   <= '0;
            cnt_q   <= '0;
            out_q   <= pat_q[0];
          end
        end
        RUN: begin
          if (!en_i || (bit_last && pat_last)) begin
            sh_v_q <= 1'b0;
            idx_q  <= '0;
            cnt_q  <= '0;
            if (nxt_v_d) begin
              pat_q     <= nxt_pat_d;
              len_q     <= nxt_len_d;
              presc_q   <= nxt_presc_d;
              oneshot_q <= nxt_oneshot_d;
            end
            if (!en_i) begin
              state_q <= IDLE;
              out_q   <= 1'b0;
            end else if (oneshot_q) begin
              state_q <= IDLE;
              out_q   <= 1'b0;
              done_q  <= 1'b1;
              armed_q <= 1'b0;
            end else if (nxt_v_d && (nxt_len_d == '0)) begin
              state_q <= IDLE;
              out_q   <= 1'b0;
            end else begin
              out_q <= nxt_v_d ? nxt_pat_d[0] : pat_q[0];
            end
          end else begin
            if (cfg_we_i) begin
              sh_v_q       <= 1'b1;
              sh_pat_q     <= cfg_pattern_i;
              sh_len_q     <= cfg_len_cl;
              sh_presc_q   <= cfg_prescale_i;
              sh_oneshot_q <= cfg_oneshot_i;
            end
            if (bit_last) begin
              idx_q <= idx_inc;
              cnt_q <= '0;
              out_q <= pat_shift[0];
            end else begin
              cnt_q <= cnt_q + PRESC_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_o     = out_q;
  assign done_o    = done_q;
  assign pending_o = sh_v_q;

endmodule

// File: rtl/multi_pattern_blinker.sv
// rtl/multi_pattern_blinker.sv - multi-channel pattern blinker top: cfg decode, ready mux, optional BLINKER_PWM_DIM_EN dimming
module multi_pattern_blinker
  import blinker_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int PAT_W    = 32,
  parameter  int PRESC_W  = 32,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int LEN_W    = len_w(PAT_W)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cfg_valid,
  output logic                o_cfg_ready,
  input  logic [CH_W-1:0]     i_cfg_ch,
  input  logic [PAT_W-1:0]    i_cfg_pattern,
  input  logic [LEN_W-1:0]    i_cfg_len,
  input  logic [PRESC_W-1:0]  i_cfg_prescale,
  input  logic                i_cfg_oneshot,
  input  logic [CHANNELS-1:0] i_en,
`ifdef BLINKER_PWM_DIM_EN
  input  logic [3:0]          i_dim,
`endif
  output logic [CHANNELS-1:0] o_out,
  output logic [CHANNELS-1:0] o_done
);

  logic [CHANNELS-1:0] cfg_we;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] ch_out;

  // Out-of-range channel numbers match no channel, so they see ready=1 and are dropped.
  always_comb begin
    o_cfg_ready = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      if ((i_cfg_ch == CH_W'(c)) && pending[c]) begin
        o_cfg_ready = 1'b0;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign cfg_we[c] = i_cfg_valid & o_cfg_ready & (i_cfg_ch == CH_W'(c));

    blink_channel #(
      .PAT_W   (PAT_W),
      .PRESC_W (PRESC_W),
      .LEN_W   (LEN_W)
    ) u_ch (
      .clk_i          (i_clk),
      .rst_i          (i_rst),
      .en_i           (i_en[c]),
      .cfg_we_i       (cfg_we[c]),
      .cfg_pattern_i  (i_cfg_pattern),
      .cfg_len_i      (i_cfg_len),
      .cfg_prescale_i (i_cfg_prescale),
      .cfg_oneshot_i  (i_cfg_oneshot),
      .out_o          (ch_out[c]),
      .done_o         (o_done[c]),
      .pending_o      (pending[c])
    );
  end

`ifdef BLINKER_PWM_DIM_EN
  logic [3:0] dim_cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dim_cnt_q <= 4'd0;
    end else begin
      dim_cnt_q <= dim_cnt_q + 4'd1;
    end
  end

  assign o_out = ch_out & {CHANNELS{dim_cnt_q < i_dim}};
`else
  assign o_out = ch_out;
`endif

endmodule

// File: tb/tb_multi_pattern_blinker.sv
// tb/tb_multi_pattern_blinker.sv - self-checking bench for multi_pattern_blinker with a cycle model
module tb_multi_pattern_blinker;
  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch = '0;
  logic [31:0] cfg_pat = '0;
  logic [5:0]  cfg_len = '0;
  logic [31:0] cfg_presc = '0;
  logic        cfg_os = 1'b0;
  logic [3:0]  en = '0;
  logic [3:0]  out;
  logic [3:0]  done;
`ifdef BLINKER_PWM_DIM_EN
  logic [3:0]  dim = 4'd15;
`endif

  int errors = 0;
  int checks = 0;

  multi_pattern_blinker dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_cfg_valid    (cfg_valid),
    .o_cfg_ready    (cfg_ready),
    .i_cfg_ch       (cfg_ch),
    .i_cfg_pattern  (cfg_pat),
    .i_cfg_len      (cfg_len),
    .i_cfg_prescale (cfg_presc),
    .i_cfg_oneshot  (cfg_os),
    .i_en           (en),
`ifdef BLINKER_PWM_DIM_EN
    .i_dim          (dim),
`endif
    .o_out          (out),
    .o_done         (done)
  );

  always #5 clk = ~clk;

  // Model: each running channel tracks cycles since start; output bit = pattern[pos / period].
  logic [31:0] m_pat [NCH];
  logic [31:0] m_spat [NCH];
  int          m_len [NCH];
  int          m_slen [NCH];
  longint      m_presc [NCH];
  longint      m_spresc [NCH];
  bit          m_os [NCH];
  bit          m_sos [NCH];
  bit          m_run [NCH];
  bit          m_armed [NCH];
  bit          m_sv [NCH];
  bit          m_out [NCH];
  bit          m_done [NCH];
  longint      m_p [NCH];
  logic [3:0]  m_dcnt;
  logic [31:0] tmp;
  longint      per;
  longint      total;
  bit          acc;
  bit          we;
  bit          os_now;

  function automatic bit m_ready();
    return !m_sv[cfg_ch];
  endfunction

  function automatic int gate(input int b);
`ifdef BLINKER_PWM_DIM_EN
    return (b != 0 && m_dcnt < dim) ? 1 : 0;
`else
    return b;
`endif
  endfunction

  task automatic m_load_in(input int c);
    m_pat[c]   = cfg_pat;
    m_len[c]   = (int'(cfg_len) > 32) ? 32 : int'(cfg_len);
    m_presc[c] = longint'(cfg_presc);
    m_os[c]    = cfg_os;
  endtask

  task automatic m_load_sh(input int c);
    m_pat[c]   = m_spat[c];
    m_len[c]   = m_slen[c];
    m_presc[c] = m_spresc[c];
    m_os[c]    = m_sos[c];
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_dcnt = 4'd0;
      for (int c = 0; c < NCH; c++) begin
        m_pat[c] = '0; m_len[c] = 0; m_presc[c] = 0; m_os[c] = 0;
        m_run[c] = 0; m_armed[c] = 1; m_sv[c] = 0; m_out[c] = 0; m_done[c] = 0; m_p[c] = 0;
      end
    end else begin
      acc = cfg_valid && m_ready();
      m_dcnt = m_dcnt + 4'd1;
      for (int c = 0; c < NCH; c++) begin
        we = acc && (int'(cfg_ch) == c);
        m_done[c] = 0;
        if (!m_run[c]) begin
          m_out[c] = 0;
          if (we) m_load_in(c);
          else if (en[c] && m_armed[c] && m_len[c] != 0) begin
            m_run[c] = 1; m_p[c] = 0; m_out[c] = m_pat[c][0];
          end
        end else begin
          per   = (m_presc[c] == 0) ? 1 : m_presc[c];
          total = longint'(m_len[c]) * per;
          if (!en[c] || m_p[c] == total - 1) begin
            os_now = m_os[c];
            if (we) m_load_in(c);
            else if (m_sv[c]) m_load_sh(c);
            m_sv[c] = 0;
            m_p[c]  = 0;
            if (!en[c] || os_now || m_len[c] == 0) begin
              m_run[c] = 0; m_out[c] = 0;
            end else begin
              m_out[c] = m_pat[c][0];
            end
            if (en[c] && os_now) begin
              m_done[c] = 1; m_armed[c] = 0;
            end
          end else begin
            if (we) begin
              m_spat[c]   = cfg_pat;
              m_slen[c]   = (int'(cfg_len) > 32) ? 32 : int'(cfg_len);
              m_spresc[c] = longint'(cfg_presc);
              m_sos[c]    = cfg_os;
              m_sv[c]     = 1;
            end
            m_p[c]   = m_p[c] + 1;
            tmp      = m_pat[c] >> (m_p[c] / per);
            m_out[c] = tmp[0];
          end
        end
        if (!en[c]) m_armed[c] = 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("model out ch%0d", c), int'(out[c]), gate(int'(m_out[c])));
      chk($sformatf("model done ch%0d", c), int'(done[c]), int'(m_done[c]));
    end
    chk("model cfg_ready", int'(cfg_ready), int'(m_ready()));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic cfg_send(input int ch, input logic [31:0] p, input int l, input int ps, input bit os);
    int k;
    cfg_ch    = 2'(ch);
    cfg_pat   = p;
    cfg_len   = 6'(l);
    cfg_presc = 32'(ps);
    cfg_os    = os;
    cfg_valid = 1'b1;
    k = 0;
    while (!cfg_ready && k < 200) begin
      cyc(1);
      k++;
    end
    if (k == 200) chk("cfg handshake timeout", 0, 1);
    cyc(1);
    cfg_valid = 1'b0;
  endtask

  bit t1_exp [12] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
  bit t2_out [6]  = '{1, 1, 0, 0, 0, 0};
  bit t2_done [6] = '{0, 0, 0, 0, 1, 0};
  bit t3_out [10] = '{0, 0, 1, 0, 1, 0, 0, 1, 1, 1};
  bit t3_rdy [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};

  initial begin
    int n_on;
    int n_done;
    int n_exp;
    #1 rst = 1'b1;
    #2;
    chk("reset out", int'(out), 0);
    chk("reset done", int'(done), 0);
    cyc(3);
    rst = 1'b0;
    #1;
    chk("ready after reset", int'(cfg_ready), 1);
    cyc(1);

    cfg_send(0, 32'hB, 4, 3, 0);
    en[0] = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cyc(1);
      chk("repeat seq ch0", int'(out[0]), gate(int'(t1_exp[i % 12])));
    end

    cfg_send(1, 32'h1, 2, 2, 1);
    en[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("oneshot out ch1", int'(out[1]), gate(int'(t2_out[i])));
      chk("oneshot done ch1", int'(done[1]), int'(t2_done[i]));
    end
    n_on = 0;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      n_on += int'(out[1]);
      n_done += int'(done[1]);
    end
    chk("oneshot no replay out", n_on, 0);
    chk("oneshot no replay done", n_done, 0);
    en[1] = 1'b0;
    cyc(1);
    en[1] = 1'b1;
    cyc(1);
    chk("oneshot replay first bit", int'(out[1]), gate(1));
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      n_done += int'(done[1]);
    end
    chk("oneshot replay done count", n_done, 1);

    cfg_send(2, 32'hA5, 8, 1, 0);
    en[2] = 1'b1;
    cyc(1);
    cyc(2);
    cfg_send(2, 32'h3C, 8, 1, 0);
    for (int i = 0; i < 10; i++) begin
      chk("shadow out ch2", int'(out[2]), gate(int'(t3_out[i])));
      chk("shadow ready ch2", int'(cfg_ready), int'(t3_rdy[i]));
      cyc(1);
    end

    cfg_send(3, 32'h1, 1, 0, 0);
    en[3] = 1'b1;
    cyc(1);
    for (int i = 0; i < 8; i++) begin
      chk("presc0 len1 out ch3", int'(out[3]), gate(1));
      cyc(1);
    end
    cfg_send(3, 32'h1, 0, 5, 0);
    for (int i = 0; i < 6; i++) begin
      chk("len0 idle ch3", int'(out[3]), 0);
      cyc(1);
    end

    en[3] = 1'b0;
    cyc(1);
    cfg_send(3, 32'hFFFF_FFFE, 40, 1, 0);
    en[3] = 1'b1;
    n_on = 0;
    n_exp = 0;
    for (int i = 0; i < 64; i++) begin
      cyc(1);
      n_on += int'(out[3]);
      n_exp += gate((i % 32 != 0) ? 1 : 0);
    end
    chk("clamped len ones ch3", n_on, n_exp);

    cfg_send(0, 32'hF, 4, 2, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("reset mid-bit out", int'(out), 0);
    chk("reset mid-bit done", int'(done), 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1);
      chk("reset held done", int'(done), 0);
    end
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      cfg_ch = 2'(c);
      #1;
      chk($sformatf("ready after mid reset ch%0d", c), int'(cfg_ready), 1);
    end
    cyc(5);
    chk("cleared config stays idle", int'(out), 0);

`ifdef BLINKER_PWM_DIM_EN
    dim = 4'd4;
    cfg_send(0, 32'hFFFF, 16, 1, 0);
    cyc(2);
    n_on = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(1);
      n_on += int'(out[0]);
    end
    chk("dim 4/16 duty", n_on, 8);
`endif

    cyc(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
